gene_mutator: RTL and testbench

GENE_MUTATOR -- requirements
Module: gene_mutator

---
 rtl/gene_mutator_if.sv | 31 +++
 rtl/gene_mutator.sv | 150 +++++++++++++++
 tb/tb_gene_mutator.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/gene_mutator_if.sv
// Gene stream interface for gene_mutator: generation control, upstream
// gene handshake, downstream gene handshake and generation status.
interface gene_mutator_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [15:0]       gen_len;
  logic [7:0]        seed;
  logic              select;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              out_mutated;
  logic [15:0]       mut_count;
  logic              gen_done;

  // Producer/consumer side (drives requests and genes, accepts results)
  modport master (
    output start, gen_len, seed, select, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mutated, mut_count, gen_done
  );

  // Mutator side
  modport slave (
    input  start, gen_len, seed, select, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mutated, mut_count, gen_done
  );
endinterface

// File: rtl/gene_mutator.sv
// gene_mutator: streams one generation of gene words through a single
// register stage, optionally flipping one bit per gene. The flipped bit
// index comes from an 8-bit Fibonacci LFSR seeded at generation start.
module gene_mutator #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  gene_mutator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1 Fibonacci step; a zero seed is never loaded.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Mutation counter saturates rather than wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Flip bit idx of d when en is set, otherwise pass d through.
  function automatic logic [DATA_W-1:0] flip_bit(
    input logic [DATA_W-1:0] d,
    input logic              en,
    input logic [IDX_W-1:0]  idx
  );
    logic [DATA_W-1:0] mask;
    mask = '0;
    if (en) mask[idx] = 1'b1;
    return d ^ mask;
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       remaining_q;
  logic [7:0]        lfsr_q;
  logic [15:0]       mut_count_q;
  logic              gen_done_q, gen_done_d;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              mut_p1;

  logic              in_ready;
  logic              in_hs;
  logic              out_hs;
  logic              start_ok;
  logic              last_in;

  // Handshake qualifiers; a gene may enter whenever the output slot is
  // empty or being emptied this cycle, giving full throughput.
  always_comb begin
    in_ready = (state_q == RUN) && (!vld_p1 || bus.out_ready);
    in_hs    = bus.in_valid && in_ready;
    out_hs   = vld_p1 && bus.out_ready;
    start_ok = (state_q == IDLE) && bus.start;
    last_in  = in_hs && (remaining_q == 16'd1);
  end

  // Next-state and generation-end decode.
  always_comb begin
    state_d    = state_q;
    gen_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          if (bus.gen_len == 16'd0) gen_done_d = 1'b1;
          else                      state_d    = RUN;
        end
      end
      RUN: begin
        if (last_in) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_hs) begin
          state_d    = IDLE;
          gen_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Generation bookkeeping: gene countdown, LFSR, mutation count, done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining_q <= 16'd0;
      lfsr_q      <= 8'h01;
      mut_count_q <= 16'd0;
      gen_done_q  <= 1'b0;
    end else begin
      gen_done_q <= gen_done_d;
      if (start_ok) begin
        remaining_q <= bus.gen_len;
        lfsr_q      <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
        mut_count_q <= 16'd0;
      end else if (in_hs) begin
        remaining_q <= remaining_q - 16'd1;
        lfsr_q      <= lfsr_next(lfsr_q);
        if (bus.select) mut_count_q <= sat_inc(mut_count_q);
      end
    end
  end

  // ---- stage p0 -> p1: gene capture and mutation ----

  // Output slot occupancy: filled by an input handshake, emptied by an
  // output handshake that is not refilled in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else if (in_hs) begin
      vld_p1 <= 1'b1;
    end else if (out_hs) begin
      vld_p1 <= 1'b0;
    end
  end

  // Output word; held while the downstream stalls since in_hs is then 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p1 <= '0;
      mut_p1  <= 1'b0;
    end else if (in_hs) begin
      data_p1 <= flip_bit(bus.in_data, bus.select, lfsr_q[IDX_W-1:0]);
      mut_p1  <= bus.select;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = vld_p1;
  assign bus.out_data    = data_p1;
  assign bus.out_mutated = mut_p1;
  assign bus.mut_count   = mut_count_q;
  assign bus.gen_done    = gen_done_q;

endmodule

// File: tb/tb_gene_mutator.sv
// Testbench for gene_mutator: directed generations plus randomized traffic,
// compared against a transaction-level model of the mutation stream.
module tb_gene_mutator;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst;

  gene_mutator_if #(.DATA_W(DATA_W)) bus ();

  gene_mutator #(.DATA_W(DATA_W), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Expected output words in order: {mutated, data}
  logic [16:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference LFSR step written as plain arithmetic on an integer.
  function automatic int model_step(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v * 2) % 256) + fb;
  endfunction

  // One whole generation. sel_mode: 0/1 constant select, 2 random.
  // rdy_mode: 0 always ready, 1 random, 2 stall 3 cycles after first output.
  // vld_mode: 0 continuous, 1 random gaps. poke: pulse start mid-run.
  task automatic run_gen(input int len, input int seed, input int sel_mode,
                         input bit rand_data, input logic [15:0] fixed,
                         input int rdy_mode, input int vld_mode, input bit poke);
    int lfsr_m;
    int sent, got, nsel, stall;
    bit first_seen, held, exp_done, done_seen;
    logic [15:0] held_data, mask;
    logic held_mut;
    logic [16:0] e;
    lfsr_m = (seed == 0) ? 1 : seed;
    sent = 0; got = 0; nsel = 0; stall = 0;
    first_seen = 0; held = 0; exp_done = 0; done_seen = 0;
    held_data = '0; held_mut = 1'b0;
    exp_q.delete();

    @(negedge clk);
    bus.start   = 1'b1;
    bus.gen_len = 16'(len);
    bus.seed    = 8'(seed);
    @(negedge clk);
    bus.start = 1'b0;

    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (held) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, held_data);
        chk("hold_mut", bus.out_mutated, held_mut);
      end
      chk("gen_done", bus.gen_done, exp_done);
      if (bus.gen_done) done_seen = 1;
      exp_done = 0;

      bus.start    = poke && (cyc == 3);
      bus.gen_len  = (poke && cyc == 3) ? 16'd2 : 16'(len);
      bus.in_valid = (sent < len) && (vld_mode == 0 || $urandom_range(0, 3) != 0);
      bus.in_data  = rand_data ? 16'($urandom) : fixed;
      bus.select   = (sel_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(sel_mode);
      if (rdy_mode == 2) begin
        if (!first_seen && bus.out_valid) begin
          first_seen = 1;
          stall = 3;
        end
        bus.out_ready = (stall == 0);
        if (stall > 0) stall--;
      end else if (rdy_mode == 1) begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;

      chk("in_ready", bus.in_ready, (sent < len) && (!bus.out_valid || bus.out_ready));
      held = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      held_mut  = bus.out_mutated;

      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e[15:0]);
          chk("out_mutated", bus.out_mutated, e[16]);
        end
        got++;
        if (got == len) exp_done = 1;
      end
      if (bus.in_valid && bus.in_ready) begin
        mask = bus.select ? 16'(1 << (lfsr_m % 16)) : 16'h0000;
        exp_q.push_back({bus.select, bus.in_data ^ mask});
        lfsr_m = model_step(lfsr_m);
        sent++;
        if (bus.select) nsel++;
      end
    end

    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("genes_out", got, len);
    chk("genes_in", sent, len);
    chk("mut_count", bus.mut_count, nsel);
    @(negedge clk);
    chk("done_one_cycle", bus.gen_done, 0);
    chk("idle_in_ready", bus.in_ready, 0);
    chk("idle_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.gen_len = '0; bus.seed = '0; bus.select = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_mutated", bus.out_mutated, 0);
    chk("rst_mut_count", bus.mut_count, 0);
    chk("rst_gen_done", bus.gen_done, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Nothing moves without start, even with traffic present.
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("pre_start_in_ready", bus.in_ready, 0);
      chk("pre_start_out_valid", bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;

    // seed 01, two all-zero genes, always mutate: bits 1 then 2.
    run_gen(2, 8'h01, 1, 1'b0, 16'h0000, 0, 0, 1'b0);
    // seed 00 behaves as seed 01.
    run_gen(1, 8'h00, 0, 1'b0, 16'hA5A5, 0, 0, 1'b0);
    run_gen(1, 8'h00, 1, 1'b0, 16'h0000, 0, 0, 1'b0);
    // Downstream stall after the first output.
    run_gen(4, 8'h5A, 2, 1'b1, 16'h0000, 2, 0, 1'b0);

    // Empty generation: no gene accepted, one done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.gen_len = 16'd0; bus.seed = 8'h33;
    @(negedge clk);
    bus.start = 1'b0;
    chk("len0_done", bus.gen_done, 1);
    chk("len0_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("len0_done_clear", bus.gen_done, 0);
    chk("len0_idle", bus.in_ready, 0);

    // Start pulsed mid-run with a different length is ignored.
    run_gen(6, 8'h77, 2, 1'b1, 16'h0000, 0, 0, 1'b1);

    // Randomized generations with random gaps and backpressure.
    for (int r = 0; r < 6; r++)
      run_gen(int'($urandom_range(1, 12)), int'($urandom_range(0, 255)), 2, 1'b1,
              16'h0000, 1, 1, 1'b0);

    // Reset while a gene is held in RUN.
    @(negedge clk);
    bus.start = 1'b1; bus.gen_len = 16'd5; bus.seed = 8'h3C;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h1234;
    bus.select = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", bus.out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_out_mutated", bus.out_mutated, 0);
    chk("mid_rst_mut_count", bus.mut_count, 0);
    chk("mid_rst_gen_done", bus.gen_done, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_gen_done", bus.gen_done, 0);
      chk("post_rst_in_ready", bus.in_ready, 0);
      chk("post_rst_out_valid", bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;
    run_gen(3, 8'hC1, 2, 1'b1, 16'h0000, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
